id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register between the decode stage and the execute stage of the 5-stage MIPS-style core. It captures decode outputs at each rising clock edge: control bits, operand values, destination register, PC and source register indices (the indices feed forwarding).
- Supports hold (downstream stall), bubble insertion (load-use hazard) and flush (taken branch).
- Tracks a valid bit and keeps saturating bubble/flush performance counters.

---
 rtl/id_ex_pipe_reg.sv | 103 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, bubble (NOP insert), flush and saturating bubble/flush counters.
// Latency: exactly 1 cycle from *_in to outputs; all outputs come straight from flops.
// Backpressure: hold freezes every output and both counters; flush overrides hold and loads a NOP.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              bubble,
   input  logic              flush,
   input  logic              wb_en_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [1:0]        branch_type_in,
   input  logic [3:0]        exe_cmd_in,
   input  logic [DATA_W-1:0] val1_in,
   input  logic [DATA_W-1:0] val2_in,
   input  logic [DATA_W-1:0] reg2_in,
   input  logic [4:0]        dest_in,
   input  logic [4:0]        src1_in,
   input  logic [4:0]        src2_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              valid_in,
   output logic              wb_en,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        branch_type,
   output logic [3:0]        exe_cmd,
   output logic [DATA_W-1:0] val1,
   output logic [DATA_W-1:0] val2,
   output logic [DATA_W-1:0] reg2,
   output logic [4:0]        dest,
   output logic [4:0]        src1,
   output logic [4:0]        src2,
   output logic [DATA_W-1:0] pc,
   output logic              valid,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   // A NOP is loaded when flush kills the slot, or when a bubble is inserted while not stalled.
   logic load_nop;
   logic load_new;
   logic bubble_hit;
   logic flush_hit;

   // Decode the per-edge update action in priority order flush > hold > bubble > load.
   always_comb begin
      load_nop   = flush | (~hold & bubble);
      load_new   = ~flush & ~hold & ~bubble;
      bubble_hit = ~flush & ~hold & bubble;
      flush_hit  = flush & valid_in;
   end

   // Pipeline register contents; control bits of an invalid instruction are suppressed.
   always_ff @(posedge clk) begin
      if (rst || load_nop) begin
         wb_en       <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         branch_type <= 2'b00;
         exe_cmd     <= 4'b0000;
         val1        <= '0;
         val2        <= '0;
         reg2        <= '0;
         dest        <= '0;
         src1        <= '0;
         src2        <= '0;
         pc          <= '0;
         valid       <= 1'b0;
      end else if (load_new) begin
         wb_en       <= wb_en_in & valid_in;
         mem_read    <= mem_read_in & valid_in;
         mem_write   <= mem_write_in & valid_in;
         branch_type <= branch_type_in & {2{valid_in}};
         exe_cmd     <= exe_cmd_in;
         val1        <= val1_in;
         val2        <= val2_in;
         reg2        <= reg2_in;
         dest        <= dest_in;
         src1        <= src1_in;
         src2        <= src2_in;
         pc          <= pc_in;
         valid       <= valid_in;
      end
   end

   // Saturating performance counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (bubble_hit && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         if (flush_hit && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios with literal expectations, then random traffic vs a model.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked on the falling edge.
// Backpressure: hold/bubble/flush are randomized together to exercise every priority combination.
module tb_id_ex_pipe_reg;
   localparam int DW  = 32;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst, hold, bubble, flush;
   logic wb_en_in, mem_read_in, mem_write_in, valid_in;
   logic [1:0] branch_type_in;
   logic [3:0] exe_cmd_in;
   logic [DW-1:0] val1_in, val2_in, reg2_in, pc_in;
   logic [4:0] dest_in, src1_in, src2_in;

   logic wb_en, mem_read, mem_write, valid;
   logic [1:0] branch_type;
   logic [3:0] exe_cmd;
   logic [DW-1:0] val1, val2, reg2, pc;
   logic [4:0] dest, src1, src2;
   logic [CW-1:0] bubble_cnt, flush_cnt;

   int checks = 0;
   int failures = 0;

   id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .hold(hold), .bubble(bubble), .flush(flush),
      .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .branch_type_in(branch_type_in), .exe_cmd_in(exe_cmd_in),
      .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
      .pc_in(pc_in), .valid_in(valid_in),
      .wb_en(wb_en), .mem_read(mem_read), .mem_write(mem_write),
      .branch_type(branch_type), .exe_cmd(exe_cmd),
      .val1(val1), .val2(val2), .reg2(reg2),
      .dest(dest), .src1(src1), .src2(src2), .pc(pc), .valid(valid),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the register should hold after each edge.
   typedef struct packed {
      logic wb_en, mem_read, mem_write;
      logic [1:0] bt;
      logic [3:0] cmd;
      logic [DW-1:0] v1, v2, r2;
      logic [4:0] dest, s1, s2;
      logic [DW-1:0] pc;
      logic valid;
   } st_t;

   st_t m;
   int  mb, mf;
   bit  model_on = 0;

   // Model update on every edge from the inputs sampled at that edge.
   always @(posedge clk) begin
      if (rst) begin
         model_on = 1;
         m  = '0;
         mb = 0;
         mf = 0;
      end else begin
         if (flush && valid_in) mf = (mf < MAX) ? mf + 1 : MAX;
         if (!flush && !hold && bubble) mb = (mb < MAX) ? mb + 1 : MAX;
         if (flush || (!hold && bubble)) begin
            m = '0;
         end else if (!hold) begin
            m.wb_en     = valid_in ? wb_en_in : 1'b0;
            m.mem_read  = valid_in ? mem_read_in : 1'b0;
            m.mem_write = valid_in ? mem_write_in : 1'b0;
            m.bt        = valid_in ? branch_type_in : 2'b00;
            m.cmd = exe_cmd_in;  m.v1 = val1_in;  m.v2 = val2_in;  m.r2 = reg2_in;
            m.dest = dest_in;    m.s1 = src1_in;  m.s2 = src2_in;  m.pc = pc_in;
            m.valid = valid_in;
         end
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_on) begin
         chk("ctrl", 64'({wb_en, mem_read, mem_write, branch_type, exe_cmd, valid}),
                     64'({m.wb_en, m.mem_read, m.mem_write, m.bt, m.cmd, m.valid}));
         chk("val1", 64'(val1), 64'(m.v1));
         chk("val2", 64'(val2), 64'(m.v2));
         chk("reg2", 64'(reg2), 64'(m.r2));
         chk("regidx", 64'({dest, src1, src2}), 64'({m.dest, m.s1, m.s2}));
         chk("pc", 64'(pc), 64'(m.pc));
         chk("bubble_cnt", 64'(bubble_cnt), 64'(mb));
         chk("flush_cnt", 64'(flush_cnt), 64'(mf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      hold = 0; bubble = 0; flush = 0;
      wb_en_in = 0; mem_read_in = 0; mem_write_in = 0; valid_in = 0;
      branch_type_in = 0; exe_cmd_in = 0;
      val1_in = 0; val2_in = 0; reg2_in = 0; pc_in = 0;
      dest_in = 0; src1_in = 0; src2_in = 0;
   endtask

   task automatic randomize_in();
      wb_en_in = 1'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
      valid_in = ($urandom_range(0, 3) != 0);
      branch_type_in = 2'($urandom); exe_cmd_in = 4'($urandom);
      val1_in = $urandom; val2_in = $urandom; reg2_in = $urandom; pc_in = $urandom;
      dest_in = 5'($urandom); src1_in = 5'($urandom); src2_in = 5'($urandom);
   endtask

   initial begin
      clear_in();
      randomize_in();
      hold = 1; bubble = 1; flush = 0;
      rst = 1;
      tick(); tick();
      chk("rst_regs", 64'({wb_en, mem_read, mem_write, branch_type, exe_cmd, valid, dest, src1, src2}), 64'd0);
      chk("rst_data", 64'(val1 | val2 | reg2 | pc), 64'd0);
      chk("rst_cnt", 64'({bubble_cnt, flush_cnt}), 64'd0);
      rst = 0;
      clear_in();

      // Normal load, then a back-to-back second instruction.
      exe_cmd_in = 4'b0001; val1_in = 32'hA; val2_in = 32'h5; dest_in = 5'd3; valid_in = 1; wb_en_in = 1;
      tick();
      chk("norm_cmd", 64'(exe_cmd), 64'h1);
      chk("norm_v1v2", 64'({val1, val2}), {32'hA, 32'h5});
      chk("norm_dest", 64'(dest), 64'd3);
      chk("norm_valid", 64'({valid, wb_en}), 64'b11);
      dest_in = 5'd7; val1_in = 32'h20;
      tick();
      chk("b2b_dest", 64'({dest, val1}), {27'd0, 5'd7, 32'h20});

      // Hold keeps instruction A for three cycles.
      pc_in = 32'h10;
      tick();
      chk("hold_load", 64'(pc), 64'h10);
      pc_in = 32'h14; hold = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_pc", 64'(pc), 64'h10);
      end
      hold = 0;
      tick();
      chk("hold_release", 64'(pc), 64'h14);

      // Bubble inserts a NOP; bubble under hold is ignored.
      bubble = 1; mem_read_in = 1; wb_en_in = 1; dest_in = 5'd5;
      tick();
      chk("bub_nop", 64'({wb_en, mem_read, dest, valid}), 64'd0);
      chk("bub_cnt", 64'(bubble_cnt), 64'd1);
      hold = 1;
      tick();
      chk("bub_hold_cnt", 64'(bubble_cnt), 64'd1);

      // Flush beats hold and bubble.
      flush = 1; valid_in = 1;
      tick();
      chk("flush_nop", 64'({valid, dest, wb_en, mem_read}), 64'd0);
      chk("flush_cnt1", 64'({flush_cnt, bubble_cnt}), 64'({4'd1, 4'd1}));
      valid_in = 0;
      tick();
      chk("flush_inv", 64'(flush_cnt), 64'd1);
      flush = 0; hold = 0; bubble = 0;

      // Invalid instruction: controls gated, data kept.
      clear_in();
      mem_write_in = 1; wb_en_in = 1; val1_in = 32'h55; valid_in = 0;
      tick();
      chk("gate_ctrl", 64'({mem_write, wb_en, valid}), 64'd0);
      chk("gate_v1", 64'(val1), 64'h55);

      // Bubble counter saturation.
      bubble = 1;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_bub", 64'(bubble_cnt), 64'd15);
      tick();
      chk("sat_bub_hold", 64'(bubble_cnt), 64'd15);
      bubble = 0;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         randomize_in();
         rst    = ($urandom_range(0, 99) < 2);
         flush  = ($urandom_range(0, 99) < 15);
         hold   = ($urandom_range(0, 99) < 25);
         bubble = ($urandom_range(0, 99) < 30);
         tick();
      end
      rst = 0; flush = 0; hold = 0; bubble = 0;
      tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
